// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, op/state encodings and request struct for shift_arb.
// Build option SHIFT_ARB_ROTATE_EN enables the rotate path in barrel_shift8.
package shift_pkg;
  localparam int SH_W = 8;
  localparam int SH_AW = 3;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA, SH_ROT} shift_op_e;
  typedef enum logic {ST_EMPTY, ST_FULL} arb_state_e;
  typedef struct packed {
    logic lr;
    logic al;
    logic rot;
    logic [SH_AW-1:0] shamt;
    logic [SH_W-1:0] din;
  } shift_req_t;
  function automatic shift_op_e op_of(shift_req_t r);
    return r.rot ? SH_ROT : r.lr ? SH_LL : r.al ? SH_RA : SH_RL;
  endfunction
endpackage

// File: rtl/barrel_shift8.sv
// barrel_shift8: combinational 8-bit shifter built from 1/2/4 log stages.
// Ports: i_req (lr, al, rot, shamt, din), o_dout (shift result).
// Macro SHIFT_ARB_ROTATE_EN: build the rotate path; otherwise rot is ignored.
module barrel_shift8
  import shift_pkg::*;
(
  input  shift_req_t       i_req,
  output logic [SH_W-1:0]  o_dout
);
  shift_req_t w_req;
`ifdef SHIFT_ARB_ROTATE_EN
  assign w_req = i_req;
`else
  logic w_unused_rot;
  assign w_unused_rot = i_req.rot;
  always_comb begin
    w_req = i_req;
    w_req.rot = 1'b0;
  end
`endif
  shift_op_e w_op;
  logic w_fill;
  logic [SH_W-1:0] w_st [SH_AW+1];
  assign w_op = op_of(w_req);
  // Sign fill always comes from the original operand msb.
  assign w_fill = (w_op == SH_RA) & i_req.din[SH_W-1];
  assign w_st[0] = i_req.din;
  for (genvar g = 0; g < SH_AW; g++) begin : g_stage
    localparam int K = 1 << g;
    logic [K-1:0] w_lfill, w_rfill;
`ifdef SHIFT_ARB_ROTATE_EN
    assign w_lfill = (w_op == SH_ROT) ? w_st[g][SH_W-1 -: K] : '0;
    assign w_rfill = (w_op == SH_ROT) ? w_st[g][K-1:0] : {K{w_fill}};
`else
    assign w_lfill = '0;
    assign w_rfill = {K{w_fill}};
`endif
    assign w_st[g+1] = !w_req.shamt[g] ? w_st[g] :
                       w_req.lr ? {w_st[g][SH_W-K-1:0], w_lfill} :
                                  {w_rfill, w_st[g][SH_W-1:K]};
  end
  assign o_dout = w_st[SH_AW];
endmodule

// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter sharing one barrel shifter between two requesters.
// Ports: clk, rst_n (async active-low); req_valid/req_ready handshake with
// req_lr/req_al/req_rot/req_shamt/req_din operands per requester;
// out_valid/out_ready handshake returning out_id and out_data.
// Macro SHIFT_ARB_ROTATE_EN: req_rot selects rotate; otherwise req_rot is ignored.
module shift_arb
  import shift_pkg::*;
#(
  parameter int W = SH_W,
  parameter int NREQ = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ-1:0]                 req_lr,
  input  logic [NREQ-1:0]                 req_al,
  input  logic [NREQ-1:0]                 req_rot,
  input  logic [NREQ-1:0][$clog2(W)-1:0]  req_shamt,
  input  logic [NREQ-1:0][W-1:0]          req_din,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_id,
  output logic [W-1:0]                    out_data
);
  arb_state_e r_state, w_state_nxt;
  logic r_rr, r_id, w_rr_nxt, w_gnt, w_any, w_can_accept, w_fire;
  logic [W-1:0] r_data, w_res;
  shift_req_t w_sel;
  assign w_any = |req_valid;
  // Pointer holder wins if asking, otherwise the other requester.
  assign w_gnt = req_valid[r_rr] ? r_rr : ~r_rr;
  assign w_sel = '{lr: req_lr[w_gnt], al: req_al[w_gnt], rot: req_rot[w_gnt],
                   shamt: req_shamt[w_gnt], din: req_din[w_gnt]};
  barrel_shift8 u_shift (
    .i_req  (w_sel),
    .o_dout (w_res)
  );
  always_comb begin
    w_can_accept = (r_state == ST_EMPTY) | (out_ready & (r_state == ST_FULL));
    w_fire = w_can_accept & w_any;
    req_ready = '0;
    req_ready[w_gnt] = w_fire;
    w_state_nxt = w_fire ? ST_FULL : out_ready ? ST_EMPTY : r_state;
    w_rr_nxt = w_fire ? ~w_gnt : r_rr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_rr <= 1'b0;
      r_id <= 1'b0;
      r_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr <= w_rr_nxt;
      if (w_fire) begin
        r_id <= w_gnt;
        r_data <= w_res;
      end
    end
  end
  assign out_valid = (r_state == ST_FULL);
  assign out_id = r_id;
  assign out_data = r_data;
endmodule
